// File: rtl/soin_pkg.sv
// soin_pkg: shared types and defaults for the instruction-fetch stage.
package soin_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} fetch_state_t;
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } if_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetched {pc, instr} entries; flush beats push.
module fetch_buffer
  import soin_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  if_entry_t     i_data,
  output logic [CW-1:0] o_count,
  output if_entry_t     o_head
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic w_full, w_push, w_pop;
  assign w_full  = r_count == CW'(DEPTH);
  assign w_pop   = i_pop && r_count != '0;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem   <= '{default: '0};
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, issues single-outstanding imem fetches and buffers
// returned instructions for decode; redirects flush the buffer and drop stale responses.
module fetch_pc_unit
  import soin_pkg::*;
#(
  parameter int               XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC  = RESET_PC_DEF[XLEN-1:0],
  parameter int               BUF_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_B_J_result,
  input  logic [XLEN-1:0] i_target,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_if_valid,
  output logic [31:0]     o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  input  logic            i_id_ready
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  fetch_state_t r_state;
  logic [XLEN-1:0] r_pc, r_addr;
  logic r_discard, r_stale;
  logic w_push, w_pop, w_flush, w_slot;
  logic [CW-1:0] w_count, w_count_nxt;
  logic [XLEN-1:0] w_tgt, w_pc_nxt;
  if_entry_t w_head;
  assign w_tgt       = i_target & ~XLEN'(3);
  assign w_pop       = o_if_valid && i_id_ready;
  assign w_flush     = i_B_J_result && r_state != IDLE;
  assign w_push      = r_state == RESP && i_imem_rvalid && !r_discard && !i_B_J_result;
  assign w_count_nxt = w_flush ? '0 : w_count + CW'(w_push) - CW'(w_pop);
  assign w_slot      = w_count_nxt < CW'(BUF_DEPTH);
  // r_stale: pc already holds a redirect target while the old request waits for gnt
  assign w_pc_nxt    = i_B_J_result ? w_tgt :
                       (r_state == REQ && i_imem_gnt && !r_stale) ? r_addr + XLEN'(4) : r_pc;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_discard <= 1'b0;
      r_stale   <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      case (r_state)
        IDLE: begin
          r_addr  <= w_pc_nxt;
          r_state <= REQ;
        end
        REQ:
          if (i_imem_gnt) begin
            r_discard <= i_B_J_result || r_stale;
            r_stale   <= 1'b0;
            r_state   <= RESP;
          end else if (i_B_J_result) r_stale <= 1'b1;
        RESP:
          if (i_imem_rvalid) begin
            r_discard <= 1'b0;
            r_state   <= w_slot ? REQ : HOLD;
            if (w_slot) r_addr <= w_pc_nxt;
          end else if (i_B_J_result) r_discard <= 1'b1;
        HOLD:
          if (w_slot) begin
            r_addr  <= w_pc_nxt;
            r_state <= REQ;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_imem_req  = r_state == REQ;
  assign o_imem_addr = r_addr;
  assign o_if_valid  = w_count != '0;
  assign o_if_instr  = w_head.instr;
  assign o_if_pc     = XLEN'(w_head.pc);
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ('{pc: XLEN_DEF'(r_addr), instr: i_imem_rdata}),
    .o_count (w_count),
    .o_head  (w_head)
  );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven and directed fetch sequences plus a randomized
// memory/decode environment checked against a fetch-stream reference model.
module tb_fetch_pc_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic bj = 1'b0, gnt = 1'b0, rvalid = 1'b0, id_ready = 1'b0;
  logic [31:0] target = '0, rdata = '0;
  logic req, if_valid;
  logic [31:0] addr, if_instr, if_pc;
  int checks = 0, failures = 0;

  fetch_pc_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_B_J_result(bj), .i_target(target),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata), .o_if_valid(if_valid),
    .o_if_instr(if_instr), .o_if_pc(if_pc), .i_id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic gnt, rv;
    logic [31:0] rdata;
    logic rdy, req;
    logic [31:0] addr;
    logic val;
    logic [31:0] pc;
  } vec_t;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bj = 0; gnt = 0; rvalid = 0; id_ready = 0; target = 0; rdata = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input logic g, input logic rv, input logic [31:0] d, input logic r,
                     input logic b = 1'b0, input logic [31:0] t = 32'h0);
    gnt = g; rvalid = rv; rdata = d; id_ready = r; bj = b; target = t;
    @(negedge clk);
  endtask

  vec_t tv[8];
  int pops, cnt;
  logic busy, held, redir_prev;
  logic [31:0] exp_pc, busy_addr, prev_addr;

  initial begin
    tv[0] = '{0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0};
    tv[1] = '{1, 0, 32'h0, 1, 1, 32'h0, 0, 32'h0};
    tv[2] = '{0, 1, f(32'h0), 1, 0, 32'h0, 0, 32'h0};
    tv[3] = '{1, 0, 32'h0, 1, 1, 32'h4, 1, 32'h0};
    tv[4] = '{0, 1, f(32'h4), 1, 0, 32'h0, 0, 32'h0};
    tv[5] = '{1, 0, 32'h0, 1, 1, 32'h8, 1, 32'h4};
    tv[6] = '{0, 1, f(32'h8), 1, 0, 32'h0, 0, 32'h0};
    tv[7] = '{0, 0, 32'h0, 1, 1, 32'hC, 1, 32'h8};

    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_valid", {31'b0, if_valid}, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, 0);

    // sequential fetch with immediate grant and next-cycle response
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tv%0d_req", i), {31'b0, req}, {31'b0, tv[i].req});
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), {31'b0, if_valid}, {31'b0, tv[i].val});
      if (tv[i].val) begin
        chk($sformatf("tv%0d_pc", i), if_pc, tv[i].pc);
        chk($sformatf("tv%0d_instr", i), if_instr, f(tv[i].pc));
      end
      cyc(tv[i].gnt, tv[i].rv, tv[i].rdata, tv[i].rdy);
    end

    // decode stalled: two entries fill the buffer, then HOLD
    do_reset();
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, f(0), 0);
    chk("full_addr4", addr, 32'h4);
    cyc(1, 0, 0, 0); cyc(0, 1, f(4), 0);
    chk("hold_req_a", {31'b0, req}, 0);
    chk("hold_valid", {31'b0, if_valid}, 1);
    cyc(0, 0, 0, 0);
    chk("hold_req_b", {31'b0, req}, 0);
    chk("hold_head", if_pc, 32'h0);
    cyc(0, 0, 0, 1);
    chk("resume_req", {31'b0, req}, 1);
    chk("resume_addr", addr, 32'h8);
    chk("resume_head", if_pc, 32'h4);

    // redirect while waiting for the 0x8 response
    do_reset();
    cyc(0, 0, 0, 1); cyc(1, 0, 0, 1); cyc(0, 1, f(0), 1); cyc(1, 0, 0, 1); cyc(0, 1, f(4), 1);
    chk("rresp_addr8", addr, 32'h8);
    cyc(1, 0, 0, 0);
    chk("rresp_buffered", {31'b0, if_valid}, 1);
    cyc(0, 0, 0, 0, 1, 32'h103);
    chk("rresp_flush", {31'b0, if_valid}, 0);
    chk("rresp_noreq", {31'b0, req}, 0);
    cyc(0, 1, f(8), 0);
    chk("rresp_req", {31'b0, req}, 1);
    chk("rresp_addr", addr, 32'h100);
    chk("rresp_drop", {31'b0, if_valid}, 0);
    cyc(1, 0, 0, 1); cyc(0, 1, f(32'h100), 1);
    chk("rresp_valid", {31'b0, if_valid}, 1);
    chk("rresp_pc", if_pc, 32'h100);
    chk("rresp_instr", if_instr, f(32'h100));

    // redirect during an ungranted request, grant arrives three cycles later
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 32'h200);
    chk("rreq_hold0", addr, 32'h0);
    cyc(0, 0, 0, 1);
    chk("rreq_hold1", addr, 32'h0);
    chk("rreq_req", {31'b0, req}, 1);
    cyc(0, 0, 0, 1); cyc(1, 0, 0, 1);
    chk("rreq_resp", {31'b0, req}, 0);
    cyc(0, 1, f(0), 1);
    chk("rreq_addr", addr, 32'h200);
    chk("rreq_drop", {31'b0, if_valid}, 0);
    cyc(1, 0, 0, 1); cyc(0, 1, f(32'h200), 1);
    chk("rreq_pc", if_pc, 32'h200);
    chk("rreq_instr", if_instr, f(32'h200));

    // redirect, rvalid and pop of the head all in one cycle
    do_reset();
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, f(0), 0); cyc(1, 0, 0, 0);
    chk("rrv_head", if_pc, 32'h0);
    cyc(0, 1, f(4), 1, 1, 32'h300);
    chk("rrv_empty", {31'b0, if_valid}, 0);
    chk("rrv_addr", addr, 32'h300);
    cyc(1, 0, 0, 1); cyc(0, 1, f(32'h300), 1);
    chk("rrv_pc", if_pc, 32'h300);
    chk("rrv_instr", if_instr, f(32'h300));

    // PC wrap, then asynchronous reset mid-response
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
    cyc(0, 1, f(0), 1);
    chk("wrap_addr", addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 1); cyc(0, 1, f(32'hFFFF_FFFC), 1);
    chk("wrap_next", addr, 32'h0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, req}, 0);
    chk("arst_valid", {31'b0, if_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1; gnt = 0;
    cyc(0, 0, 0, 1);
    chk("arst_restart", addr, 32'h0);
    chk("arst_restart_req", {31'b0, req}, 1);

    // randomized memory latency, decode stalls and redirects
    do_reset();
    exp_pc = 0; busy = 0; held = 0; redir_prev = 0; pops = 0; cnt = 0;
    busy_addr = 0; prev_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (req) begin
        chk("one_outstanding", {31'b0, busy}, 0);
        chk("addr_align", {30'b0, addr[1:0]}, 0);
        if (held) chk("addr_stable", addr, prev_addr);
      end
      if (redir_prev) chk("flush_valid", {31'b0, if_valid}, 0);
      id_ready = ($urandom % 4) != 0;
      gnt = req && ($urandom % 2 == 1);
      rvalid = busy && cnt == 0;
      rdata = rvalid ? f(busy_addr) : $urandom;
      bj = ($urandom % 20) == 0;
      target = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      if (if_valid && id_ready) begin
        chk("rnd_pc", if_pc, exp_pc);
        chk("rnd_instr", if_instr, f(exp_pc));
        exp_pc += 4;
        pops++;
      end
      if (bj) exp_pc = target & ~32'd3;
      if (rvalid) busy = 0;
      else if (busy) cnt--;
      if (gnt) begin
        busy = 1;
        busy_addr = addr;
        cnt = $urandom_range(0, 2);
      end
      held = req && !gnt;
      prev_addr = addr;
      redir_prev = bj;
      @(negedge clk);
    end
    chk("rnd_progress", {31'b0, pops >= 100}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
